spi_target_loader: RTL
======================

# spi_target_loader

SPI responder (target) that lets an external host read and write the SoC's word-addressed memories over a 4-wire SPI link while the CPU is held in reset. It complements the flash controller, which acts as SPI initiator toward the boot flash. The block sits beside the bus as an alternate bus master. It turns SPI frames into single-word write or read requests carrying a ready handshake, so the host can load program memory without reflashing.

## Interface
- `ADDR_BITS`, default 24: width of the byte address carried in a frame. Three address bytes are always sent; the upper bits are zero-extended onto `mem_addr`.
- `clk` input, 1 bit: system clock. Every register is in this domain.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `spi_sck` input, 1 bit: host serial clock, asynchronous. It must not exceed clk/4.
- `spi_cs_n` input, 1 bit: host chip select, active-low, asynchronous.
- `spi_mosi` input, 1 bit: host-to-target data, MSB first.
- `spi_miso` output, 1 bit: target-to-host data. Driven 0 whenever no data is being shifted out.
- `mem_wen` output, 1 bit: write request. Held until `mem_ready`.
- `mem_ren` output, 1 bit: read request. Held until `mem_ready`.
- `mem_addr` output, 32 bits: byte address. Bits [1:0] are always 0.
- `mem_wdata` output, 32 bits: write data.
- `mem_byte_select` output, 4 bits: 4'b1111 while `mem_wen` or `mem_ren` is high, else 0.
- `mem_rdata` input, 32 bits: read data, valid with `mem_ready`.
- `mem_ready` input, 1 bit: completes the current request.
- `busy` output, 1 bit: high while `spi_cs_n` is low or a request is outstanding.

## Operation
- **SPI mode and synchronisation:** SPI mode 0. `spi_sck`, `spi_cs_n` and `spi_mosi` each pass through a 2-flop synchronizer. A rising SCK edge samples MOSI. A falling SCK edge shifts the next MISO bit.
- **Frame format:** command byte, then 3 address bytes (MSB first), then payload. The address bits [1:0] are ignored and forced to 0. `spi_cs_n` rising aborts the frame in any state and returns to IDLE. A partially received word is discarded, but a request already issued completes.
- **States:**
  - IDLE: CS falling → CMD.
  - CMD: 8 bits received → decode.
  - ADDR: 24 bits received → WDATA, DUMMY or IGNORE.
  - DUMMY: 8 bits received → RDATA.
  - WDATA, RDATA, STATUS: stay until CS rises.
  - IGNORE: stay until CS rises.
- **Command 0x02, write:**
  - Every 32 MOSI bits form a word.
  - The word is issued as `mem_wen` with `mem_addr` and `mem_wdata`.
  - `mem_addr` then increments by 4, wrapping modulo 2^ADDR_BITS.
  - If a word completes while a previous request is still pending, that word is dropped and the sticky `ovf` flag is set.
- **Command 0x03, read** (see Configuration):
  - When ADDR completes, `mem_ren` is raised for the current address.
  - On `mem_ready`, the read data is latched into a prefetch register and the address increments by 4.
  - At each word boundary in RDATA, the prefetch register is loaded into the MISO shift register and the next read is issued immediately.
  - If no data is present at a word boundary, 32'h0 is shifted out and `ovf` is set.
- **Command 0x05, status:**
  - MISO returns {6'b0, ovf, pending}, repeated every byte.
  - `ovf` clears when the status byte's last bit has been shifted.
- **Any other opcode:** goes to IGNORE, with MISO held at 0.

## Timing
- **Reset values:** every output is 0, the state is IDLE, `ovf` is 0 and the address is 0.
- **Input latency:** 2 clk of synchronizer delay plus 1 clk of edge detection.
- **Write latency:** `mem_wen` rises 3–4 clk after the SCK rising edge that carries the word's 32nd bit.
- **Request handshake:**
  - A request stays high, with address and data stable, through the cycle in which `mem_ready` is sampled high.
  - It drops the following cycle.
  - Only one request is outstanding at a time.
  - A memory that returns `mem_ready` in the same cycle gives a 1-cycle pulse.
- **Read deadline:** the dummy byte gives at least 32 clk for the first fetch. Each later fetch must complete within 32 SCK periods.
- **MISO output:** the MSB of a read word is valid after the first falling SCK edge following the dummy byte. MISO changes only on synchronized SCK falling edges.
- **CS and SCK together:** when CS rises in the same cycle as an SCK edge, CS wins.
- **Reset during a request:** an asynchronous `reset` drops the request immediately, with no completion.

## Configuration
- `SPI_LOADER_READBACK_EN`
  - **Defined:** command 0x03 works as described.
  - **Undefined:** 0x03 decodes as unknown and goes to IGNORE, `mem_ren` is tied to 0, and no prefetch register is synthesized. Write and status behaviour is identical in both builds.

## Structure
- The shared package `spi_loader_pkg` holds:
  - the opcode constants CMD_WRITE = 8'h02, CMD_READ = 8'h03 and CMD_STATUS = 8'h05;
  - the state enumeration;
  - the STATUS bit positions.
- One sub-module, `spi_sync_edge`: a 2-flop synchronizer with a registered previous value. It outputs the synchronized level plus rise and fall strobes, and is instantiated once per SPI input (once each for SCK, CS_n and MOSI; MOSI uses only the level).
- Target size is about 250 lines of RTL in the top module.

## Test plan
- **Write one word:** CS low, send 02 00 01 00 DE AD BE EF, CS high → one `mem_wen` with `mem_addr` = 0x100, `mem_wdata` = 0xDEADBEEF and `mem_byte_select` = 4'hF.
- **Streamed write with slow memory:** two words to address 0x0FC, with `mem_ready` delayed 5 clk → writes go to 0x0FC and then 0x100, and `wen` is held for exactly 6 clk each.
- **Readback:** memory returns 0x12345678 for address 0x200; send 03 00 02 03 plus a dummy byte → `mem_addr` = 0x200 (low bits masked), MISO returns 0x12345678, and the next prefetch goes to 0x204.
- **Overflow:** `mem_ready` held low while two words are streamed → the second word is dropped; a following 05 frame returns 8'h03, and a second 05 frame returns 8'h00.
- **Abort:** CS rises after 12 data bits of a write → no `mem_wen`, state is IDLE, and a following valid write succeeds.
- **Reset and build option:** `reset` asserted mid-request → `mem_wen` = 0 in the same cycle. Build without `SPI_LOADER_READBACK_EN`, then send 03 → `mem_ren` never rises and MISO stays 0.

Source files
------------

// File: rtl/spi_loader_pkg.sv
// spi_loader_pkg: shared opcodes, FSM states and STATUS layout
// for the SPI target loader.
package spi_loader_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  localparam int ST_PENDING = 0;
  localparam int ST_OVF     = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_WDATA,
    S_RDATA,
    S_STATUS,
    S_IGNORE
  } state_t;

  function automatic logic [7:0] status_byte(
    input logic ovf,
    input logic pending
  );
    logic [7:0] b;
    b = 8'h00;
    b[ST_OVF] = ovf;
    b[ST_PENDING] = pending;
    return b;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer plus previous-value register.
// Ports: clk, reset, din -> level, rise and fall strobes (1 clk each).
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;
  assign fall  = ~s2 & prev;

endmodule

// File: rtl/spi_target_loader.sv
// spi_target_loader: SPI mode-0 target turning frames into single-word
// memory requests. Optional readback build: SPI_LOADER_READBACK_EN.
// Ports: clk/reset; spi_sck/spi_cs_n/spi_mosi in, spi_miso out;
// mem_wen/mem_ren/mem_addr/mem_wdata/mem_byte_select out with
// mem_rdata/mem_ready in; busy while selected or request pending.
module spi_target_loader
  import spi_loader_pkg::*;
#(
  parameter int ADDR_BITS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_select,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  localparam logic [23:0] ADDR_MASK = 24'hFFFFFC;

  logic sck_rise, sck_fall, unused_sck_lvl;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .reset(reset), .din(spi_sck),
    .level(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .din(spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .din(spi_mosi),
    .level(mosi), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  state_t state_q, state_d, cmd_state;

  logic [4:0]           cnt_q;
  logic [30:0]          rx_q;
  logic [31:0]          rx_next;
  logic [7:0]           cmd_q;
  logic [ADDR_BITS-1:0] addr_q, addr_inc;
  logic [31:0]          wdata_q, tx_q;
  logic wen_q, ren_q, ovf_q, miso_q;
  logic pending, field_done, rx_en, bit_end;

`ifdef SPI_LOADER_READBACK_EN
  logic [31:0] pf_q;
  logic        pf_valid_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  // CS wins over a coincident SCK edge.
  assign rx_en    = sck_rise & ~cs_rise & (state_q != S_IDLE);
  assign bit_end  = rx_en & field_done;
  assign rx_next  = {rx_q, mosi};
  assign pending  = wen_q | ren_q;
  assign addr_inc = addr_q + ADDR_BITS'(4);

  always_comb begin
    field_done = 1'b0;
    unique case (state_q)
      S_CMD, S_DUMMY, S_STATUS: field_done = (cnt_q == 5'd7);
      S_ADDR:                   field_done = (cnt_q == 5'd23);
      S_WDATA, S_RDATA:         field_done = (cnt_q == 5'd31);
      default:                  field_done = 1'b0;
    endcase
  end

  always_comb begin
    cmd_state = S_IGNORE;
    unique case (1'b1)
      rx_next[7:0] == CMD_WRITE:  cmd_state = S_ADDR;
`ifdef SPI_LOADER_READBACK_EN
      rx_next[7:0] == CMD_READ:   cmd_state = S_ADDR;
`endif
      rx_next[7:0] == CMD_STATUS: cmd_state = S_STATUS;
      default:                    cmd_state = S_IGNORE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (cs_fall) state_d = S_CMD;
        S_CMD:   if (bit_end) state_d = cmd_state;
        S_ADDR:
          if (bit_end)
            state_d = (cmd_q == CMD_WRITE) ? S_WDATA : S_DUMMY;
        S_DUMMY: if (bit_end) state_d = S_RDATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      rx_q    <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      ovf_q   <= 1'b0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
`ifdef SPI_LOADER_READBACK_EN
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
`endif
    end else begin
      if (state_q == S_IDLE) cnt_q <= '0;
      else if (rx_en) cnt_q <= field_done ? 5'd0 : cnt_q + 5'd1;

      if (rx_en) rx_q <= rx_next[30:0];

      if (wen_q && mem_ready) begin
        wen_q  <= 1'b0;
        addr_q <= addr_inc;
      end
`ifdef SPI_LOADER_READBACK_EN
      if (ren_q && mem_ready) begin
        ren_q      <= 1'b0;
        pf_q       <= mem_rdata;
        pf_valid_q <= 1'b1;
        addr_q     <= addr_inc;
      end
`endif

      // MISO only moves on SCK falls; idle frames force it low.
      if (cs_rise || state_q == S_IDLE) begin
        tx_q   <= '0;
        miso_q <= 1'b0;
      end else if (sck_fall) begin
        miso_q <= tx_q[31];
        tx_q   <= {tx_q[30:0], 1'b0};
      end

      if (bit_end) begin
        unique case (state_q)
          S_CMD: begin
            cmd_q <= rx_next[7:0];
            tx_q  <= (rx_next[7:0] == CMD_STATUS) ?
                     {status_byte(ovf_q, pending), 24'h0} : '0;
          end
          S_ADDR: begin
            addr_q <= ADDR_BITS'(rx_next[23:0] & ADDR_MASK);
`ifdef SPI_LOADER_READBACK_EN
            if (cmd_q == CMD_READ) begin
              ren_q      <= 1'b1;
              pf_valid_q <= 1'b0;
            end
`endif
          end
          // The byte just shifted carried ovf, so the reload shows it clear.
          S_STATUS: begin
            ovf_q <= 1'b0;
            tx_q  <= {status_byte(1'b0, pending), 24'h0};
          end
          S_WDATA: begin
            if (pending) begin
              ovf_q <= 1'b1;
            end else begin
              wen_q   <= 1'b1;
              wdata_q <= rx_next;
            end
          end
`ifdef SPI_LOADER_READBACK_EN
          S_DUMMY, S_RDATA: begin
            if (pf_valid_q) begin
              tx_q       <= pf_q;
              pf_valid_q <= 1'b0;
              if (!pending) ren_q <= 1'b1;
            end else begin
              tx_q  <= '0;
              ovf_q <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_LOADER_READBACK_EN
  assign mem_ren = ren_q;
`else
  assign mem_ren = 1'b0;
`endif

  assign spi_miso        = miso_q;
  assign mem_wen         = wen_q;
  assign mem_addr        = 32'(addr_q);
  assign mem_wdata       = wdata_q;
  assign mem_byte_select = (wen_q | mem_ren) ? 4'hF : 4'h0;
  assign busy            = ~cs_lvl | pending;

endmodule
